// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the dual-write-port register file: pipes write through,
// long-latency results queue in a small FIFO and drain into idle write ports.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p0_we,
    input  logic [4:0]                p0_waddr,
    input  logic [31:0]               p0_wdata,
    input  logic                      p1_we,
    input  logic [4:0]                p1_waddr,
    input  logic [31:0]               p1_wdata,
    input  logic                      ll_valid,
    output logic                      ll_ready,
    input  logic [4:0]                ll_waddr,
    input  logic [31:0]               ll_wdata,
    output logic                      we1,
    output logic [4:0]                waddr1,
    output logic [31:0]               wdata1,
    output logic                      we2,
    output logic [4:0]                waddr2,
    output logic [31:0]               wdata2,
    output logic [31:0]               pend_mask,
    output logic [$clog2(DEPTH):0]    ll_count,
    output logic                      stall_req
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    logic          w_p0_act;
    logic          w_p1_act;
    logic          w_has1;
    logic          w_has2;
    logic [AW-1:0] w_next_idx;
    logic [1:0]    w_pops;
    logic          w_push;

    assign w_p0_act   = p0_we && (p0_waddr != 5'd0);
    assign w_p1_act   = p1_we && (p1_waddr != 5'd0);
    assign w_has1     = (r_count != CW'(0));
    assign w_has2     = (r_count >= CW'(2));
    assign w_next_idx = r_head + AW'(1);

    // Ready depends only on registered occupancy; pops this cycle do not raise it.
    assign ll_ready  = !rst && (r_count < CW'(DEPTH));
    assign w_push    = ll_valid && ll_ready && (ll_waddr != 5'd0);
    assign ll_count  = r_count;
    assign stall_req = !rst && (r_starve == SW'(STARVE_LIMIT));

    // Port selection: pipes own their fixed port, FIFO head fills whatever is idle.
    always_comb begin
        we1    = 1'b0;
        waddr1 = 5'd0;
        wdata1 = 32'd0;
        we2    = 1'b0;
        waddr2 = 5'd0;
        wdata2 = 32'd0;
        w_pops = 2'd0;
        if (!rst) begin
            if (w_p0_act) begin
                we1    = 1'b1;
                waddr1 = p0_waddr;
                wdata1 = p0_wdata;
            end
            if (w_p1_act) begin
                we2    = 1'b1;
                waddr2 = p1_waddr;
                wdata2 = p1_wdata;
            end
            case ({w_p0_act, w_p1_act})
                2'b01: begin
                    if (w_has1) begin
                        we1    = 1'b1;
                        waddr1 = r_addr[r_head];
                        wdata1 = r_data[r_head];
                        w_pops = 2'd1;
                    end
                end
                2'b10: begin
                    if (w_has1) begin
                        we2    = 1'b1;
                        waddr2 = r_addr[r_head];
                        wdata2 = r_data[r_head];
                        w_pops = 2'd1;
                    end
                end
                2'b00: begin
                    if (w_has2) begin
                        we1    = 1'b1;
                        waddr1 = r_addr[r_head];
                        wdata1 = r_data[r_head];
                        we2    = 1'b1;
                        waddr2 = r_addr[w_next_idx];
                        wdata2 = r_data[w_next_idx];
                        w_pops = 2'd2;
                    end else if (w_has1) begin
                        we1    = 1'b1;
                        waddr1 = r_addr[r_head];
                        wdata1 = r_data[r_head];
                        w_pops = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pending mask covers every valid entry, including ones draining this cycle.
    always_comb begin
        pend_mask = 32'd0;
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (CW'(k) < r_count) begin
                    pend_mask[r_addr[r_head + AW'(k)]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= ll_waddr;
            r_data[r_tail] <= ll_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            r_head  <= r_head + AW'(w_pops);
            r_count <= r_count + CW'(w_push) - CW'(w_pops);
        end
    end

    // Starve counter: age of an undrained head, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_has1 || (w_pops != 2'd0)) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_LIMIT)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, pipe pass-through, FIFO drain,
// back-pressure and starvation, each scenario checked inline.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_we;
    logic [4:0]  p0_waddr;
    logic [31:0] p0_wdata;
    logic        p1_we;
    logic [4:0]  p1_waddr;
    logic [31:0] p1_wdata;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        we2;
    logic [4:0]  waddr2;
    logic [31:0] wdata2;
    logic [31:0] pend_mask;
    logic [2:0]  ll_count;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_we(p0_we), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
        .p1_we(p1_we), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .pend_mask(pend_mask), .ll_count(ll_count), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pipes(input logic a0, input logic a1);
        p0_we = a0; p0_waddr = 5'd10; p0_wdata = 32'hAA;
        p1_we = a1; p1_waddr = 5'd11; p1_wdata = 32'hBB;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_we = 1'b1; p0_waddr = 5'd5; p0_wdata = 32'h55;
        p1_we = 1'b1; p1_waddr = 5'd6; p1_wdata = 32'h66;
        ll_valid = 1'b1; ll_waddr = 5'd3; ll_wdata = 32'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL rst_ready cyc%0d got=%b exp=0", i, ll_ready); end
            total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall cyc%0d got=%b exp=0", i, stall_req); end
            total++; if (pend_mask !== 32'd0) begin bad++; $display("FAIL rst_pend cyc%0d got=%h exp=0", i, pend_mask); end
            total++; if ({we1, we2} !== 2'b00) begin bad++; $display("FAIL rst_we cyc%0d got=%b exp=00", i, {we1, we2}); end
            total++; if ({waddr1, wdata1, waddr2, wdata2} !== 74'd0) begin bad++; $display("FAIL rst_wport cyc%0d got=%h exp=0", i, {waddr1, wdata1, waddr2, wdata2}); end
            total++; if (ll_count !== 3'd0) begin bad++; $display("FAIL rst_count cyc%0d got=%0d exp=0", i, ll_count); end
        end
        rst = 1'b0;
        pipes(1'b0, 1'b0);
        ll_valid = 1'b0;
        @(negedge clk);
        total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", ll_ready); end
        total++; if (ll_count !== 3'd0) begin bad++; $display("FAIL idle_count got=%0d exp=0", ll_count); end
        total++; if ({we1, we2} !== 2'b00) begin bad++; $display("FAIL idle_we got=%b exp=00", {we1, we2}); end
    endtask

    task automatic test_pipes();
        next_cycle();
        p0_we = 1'b1; p0_waddr = 5'd5; p0_wdata = 32'hA;
        p1_we = 1'b1; p1_waddr = 5'd5; p1_wdata = 32'hB;
        @(negedge clk);
        total++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd5, 32'hA}) begin bad++; $display("FAIL pipe_p1 got=%b/%0d/%h exp=1/5/a", we1, waddr1, wdata1); end
        total++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd5, 32'hB}) begin bad++; $display("FAIL pipe_p2 got=%b/%0d/%h exp=1/5/b", we2, waddr2, wdata2); end
        next_cycle();
        p0_waddr = 5'd0; p1_we = 1'b0;
        @(negedge clk);
        total++; if ({we1, we2} !== 2'b00) begin bad++; $display("FAIL pipe_r0 got=%b exp=00", {we1, we2}); end
        next_cycle();
        p0_we = 1'b0; p1_we = 1'b1; p1_waddr = 5'd9; p1_wdata = 32'h99;
        @(negedge clk);
        total++; if ({we1, we2, waddr2} !== {2'b01, 5'd9}) begin bad++; $display("FAIL pipe_map got=%b%b/%0d exp=01/9", we1, we2, waddr2); end
    endtask

    task automatic test_single();
        next_cycle();
        pipes(1'b0, 1'b0);
        ll_valid = 1'b1; ll_waddr = 5'd7; ll_wdata = 32'h1234;
        @(negedge clk);
        total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", ll_ready); end
        total++; if ({we1, pend_mask} !== 33'd0) begin bad++; $display("FAIL single_nobypass got=%b/%h exp=0/0", we1, pend_mask); end
        next_cycle();
        ll_valid = 1'b0;
        @(negedge clk);
        total++; if (ll_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", ll_count); end
        total++; if (pend_mask !== 32'h80) begin bad++; $display("FAIL single_pend got=%h exp=80", pend_mask); end
        total++; if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd7, 32'h1234, 1'b0}) begin bad++; $display("FAIL single_drain got=%b/%0d/%h/%b exp=1/7/1234/0", we1, waddr1, wdata1, we2); end
        next_cycle();
        @(negedge clk);
        total++; if ({pend_mask, ll_count, we1} !== 36'd0) begin bad++; $display("FAIL single_clear got=%h/%0d/%b exp=0/0/0", pend_mask, ll_count, we1); end
    endtask

    task automatic test_dual();
        next_cycle();
        pipes(1'b1, 1'b1);
        ll_valid = 1'b1; ll_waddr = 5'd3; ll_wdata = 32'd1;
        @(negedge clk);
        total++; if ({waddr1, waddr2} !== {5'd10, 5'd11}) begin bad++; $display("FAIL dual_pipeown got=%0d/%0d exp=10/11", waddr1, waddr2); end
        next_cycle();
        ll_waddr = 5'd4; ll_wdata = 32'd2;
        next_cycle();
        ll_valid = 1'b0; pipes(1'b0, 1'b0);
        @(negedge clk);
        total++; if ({ll_count, pend_mask} !== {3'd2, 32'h18}) begin bad++; $display("FAIL dual_state got=%0d/%h exp=2/18", ll_count, pend_mask); end
        total++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd3, 32'd1}) begin bad++; $display("FAIL dual_p1 got=%b/%0d/%h exp=1/3/1", we1, waddr1, wdata1); end
        total++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd4, 32'd2}) begin bad++; $display("FAIL dual_p2 got=%b/%0d/%h exp=1/4/2", we2, waddr2, wdata2); end
        next_cycle();
        @(negedge clk);
        total++; if (ll_count !== 3'd0) begin bad++; $display("FAIL dual_empty got=%0d exp=0", ll_count); end
        next_cycle();
        pipes(1'b1, 1'b1);
        ll_valid = 1'b1; ll_waddr = 5'd3; ll_wdata = 32'd1;
        next_cycle();
        ll_waddr = 5'd4; ll_wdata = 32'd2;
        next_cycle();
        ll_valid = 1'b0; pipes(1'b1, 1'b0);
        @(negedge clk);
        total++; if ({we1, waddr1, wdata1} !== {1'b1, 5'd10, 32'hAA}) begin bad++; $display("FAIL p0only_p1 got=%b/%0d/%h exp=1/10/aa", we1, waddr1, wdata1); end
        total++; if ({we2, waddr2, wdata2} !== {1'b1, 5'd3, 32'd1}) begin bad++; $display("FAIL p0only_p2 got=%b/%0d/%h exp=1/3/1", we2, waddr2, wdata2); end
        next_cycle();
        pipes(1'b0, 1'b0);
        @(negedge clk);
        total++; if ({ll_count, pend_mask} !== {3'd1, 32'h10}) begin bad++; $display("FAIL p0only_state got=%0d/%h exp=1/10", ll_count, pend_mask); end
        total++; if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd4, 32'd2, 1'b0}) begin bad++; $display("FAIL p0only_rest got=%b/%0d/%h/%b exp=1/4/2/0", we1, waddr1, wdata1, we2); end
        next_cycle();
    endtask

    task automatic test_push_pop();
        next_cycle();
        pipes(1'b1, 1'b1);
        ll_valid = 1'b1; ll_waddr = 5'd12; ll_wdata = 32'hC;
        next_cycle();
        pipes(1'b0, 1'b0);
        ll_waddr = 5'd13; ll_wdata = 32'hD;
        @(negedge clk);
        total++; if ({ll_count, ll_ready, we1, waddr1, wdata1} !== {3'd1, 1'b1, 1'b1, 5'd12, 32'hC}) begin bad++; $display("FAIL pushpop_a got=%0d/%b/%b/%0d/%h exp=1/1/1/12/c", ll_count, ll_ready, we1, waddr1, wdata1); end
        next_cycle();
        ll_valid = 1'b0;
        @(negedge clk);
        total++; if ({ll_count, we1, waddr1, wdata1} !== {3'd1, 1'b1, 5'd13, 32'hD}) begin bad++; $display("FAIL pushpop_b got=%0d/%b/%0d/%h exp=1/1/13/d", ll_count, we1, waddr1, wdata1); end
        next_cycle();
        ll_valid = 1'b1; ll_waddr = 5'd0; ll_wdata = 32'hEE;
        @(negedge clk);
        total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", ll_ready); end
        next_cycle();
        ll_valid = 1'b0;
        @(negedge clk);
        total++; if ({ll_count, we1, pend_mask} !== 36'd0) begin bad++; $display("FAIL zero_drop got=%0d/%b/%h exp=0/0/0", ll_count, we1, pend_mask); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            pipes(1'b1, 1'b1);
            ll_valid = 1'b1; ll_waddr = 5'(20 + i); ll_wdata = 32'(100 + i);
            @(negedge clk);
            total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL full_acc%0d got=%b exp=1", i, ll_ready); end
        end
        next_cycle();
        ll_waddr = 5'd24; ll_wdata = 32'd104;
        @(negedge clk);
        total++; if ({ll_ready, ll_count, pend_mask} !== {1'b0, 3'd4, 32'h00F00000}) begin bad++; $display("FAIL full_state got=%b/%0d/%h exp=0/4/00f00000", ll_ready, ll_count, pend_mask); end
        next_cycle();
        @(negedge clk);
        total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b exp=0", ll_ready); end
        next_cycle();
        pipes(1'b1, 1'b0);
        @(negedge clk);
        total++; if ({we2, waddr2, wdata2, ll_ready} !== {1'b1, 5'd20, 32'd100, 1'b0}) begin bad++; $display("FAIL full_drain got=%b/%0d/%0d/%b exp=1/20/100/0", we2, waddr2, wdata2, ll_ready); end
        total++; if ({we1, waddr1} !== {1'b1, 5'd10}) begin bad++; $display("FAIL full_p0 got=%b/%0d exp=1/10", we1, waddr1); end
        next_cycle();
        pipes(1'b1, 1'b1);
        @(negedge clk);
        total++; if ({ll_count, ll_ready} !== {3'd3, 1'b1}) begin bad++; $display("FAIL full_reopen got=%0d/%b exp=3/1", ll_count, ll_ready); end
        next_cycle();
        ll_valid = 1'b0;
        @(negedge clk);
        total++; if ({ll_count, ll_ready, pend_mask} !== {3'd4, 1'b0, 32'h01E00000}) begin bad++; $display("FAIL full_fifth got=%0d/%b/%h exp=4/0/01e00000", ll_count, ll_ready, pend_mask); end
        next_cycle();
        pipes(1'b0, 1'b0);
        @(negedge clk);
        total++; if ({waddr1, wdata1, waddr2, wdata2} !== {5'd21, 32'd101, 5'd22, 32'd102}) begin bad++; $display("FAIL full_wrap1 got=%0d/%0d/%0d/%0d exp=21/101/22/102", waddr1, wdata1, waddr2, wdata2); end
        next_cycle();
        @(negedge clk);
        total++; if ({ll_count, waddr1, wdata1, waddr2, wdata2} !== {3'd2, 5'd23, 32'd103, 5'd24, 32'd104}) begin bad++; $display("FAIL full_wrap2 got=%0d/%0d/%0d/%0d/%0d exp=2/23/103/24/104", ll_count, waddr1, wdata1, waddr2, wdata2); end
        next_cycle();
        @(negedge clk);
        total++; if (ll_count !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d exp=0", ll_count); end
    endtask

    task automatic test_starve();
        next_cycle();
        pipes(1'b1, 1'b1);
        ll_valid = 1'b1; ll_waddr = 5'd9; ll_wdata = 32'h99;
        next_cycle();
        ll_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_early n+%0d got=%b exp=0", k, stall_req); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL starve_rise got=%b exp=1", stall_req); end
        next_cycle();
        @(negedge clk);
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL starve_sat got=%b exp=1", stall_req); end
        next_cycle();
        pipes(1'b1, 1'b0);
        @(negedge clk);
        total++; if ({stall_req, we2, waddr2, wdata2} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin bad++; $display("FAIL starve_drain got=%b/%b/%0d/%h exp=1/1/9/99", stall_req, we2, waddr2, wdata2); end
        next_cycle();
        pipes(1'b1, 1'b1);
        @(negedge clk);
        total++; if ({stall_req, ll_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL starve_drop got=%b/%0d exp=0/0", stall_req, ll_count); end
        next_cycle();
        pipes(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pipes();
        test_single();
        test_dual();
        test_push_pop();
        test_full();
        test_starve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
